fir_lowpass_8tap: RTL and testbench

- 8-tap direct-form FIR low-pass filter for one signed 16-bit sample stream. One sample is taken on every rising CLK edge, so the sample rate equals the clock rate (1 MHz nominal).
- With the default coefficients, 100 kHz passes, 200 kHz is attenuated, and fs/4 (250 kHz) and fs/2 are nulled exactly.
- Used as the front-end smoothing stage ahead of FFT processing.

---
 rtl/fir_lowpass_8tap.sv | 74 +++++++
 tb/tb_fir_lowpass_8tap.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fir_lowpass_8tap.sv
// 8-tap direct-form FIR low-pass, signed Q15 in, full-precision Q30 out, one sample per clock.
// Define FIR_SYMMETRIC_FOLD_EN to pre-add mirrored taps and use only H0..H3 (symmetric sets only).
module fir_lowpass_8tap #(
    parameter logic signed [15:0] H0 = 16'sd910,
    parameter logic signed [15:0] H1 = 16'sd2730,
    parameter logic signed [15:0] H2 = 16'sd5460,
    parameter logic signed [15:0] H3 = 16'sd7280,
    parameter logic signed [15:0] H4 = 16'sd7280,
    parameter logic signed [15:0] H5 = 16'sd5460,
    parameter logic signed [15:0] H6 = 16'sd2730,
    parameter logic signed [15:0] H7 = 16'sd910
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [15:0] X,
    output logic signed [31:0] Y
);

    localparam int unsigned NTAPS = 8;
    localparam int unsigned XW    = 16;
    localparam int unsigned SW    = XW + 1;
    localparam int unsigned YW    = 32;

    localparam logic signed [XW-1:0] COEF [NTAPS] = '{H0, H1, H2, H3, H4, H5, H6, H7};

    logic signed [XW-1:0] hist   [NTAPS-1];
    logic signed [XW-1:0] taps_c [NTAPS];
    logic signed [YW-1:0] acc_c;

    // Tap 0 is the live input; older taps come from the history line.
    always_comb begin
        taps_c[0] = X;
        for (int k = 1; k < int'(NTAPS); k++) begin
            taps_c[k] = hist[k-1];
        end
    end

`ifdef FIR_SYMMETRIC_FOLD_EN
    logic signed [SW-1:0] pre_c [NTAPS/2];

    // Mirrored taps share a coefficient; mod-2^32 wrap keeps the result identical to the unfolded sum.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < int'(NTAPS/2); k++) begin
            pre_c[k] = SW'(taps_c[k]) + SW'(taps_c[int'(NTAPS) - 1 - k]);
            acc_c    = acc_c + YW'(COEF[k]) * YW'(pre_c[k]);
        end
    end
`else
    // Full 16x16 products accumulated in 32 bits, wrapping on overflow.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < int'(NTAPS); k++) begin
            acc_c = acc_c + YW'(COEF[k]) * YW'(taps_c[k]);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Y <= '0;
            for (int k = 0; k < int'(NTAPS) - 1; k++) begin
                hist[k] <= '0;
            end
        end else begin
            Y       <= acc_c;
            hist[0] <= X;
            for (int k = 1; k < int'(NTAPS) - 1; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_lowpass_8tap.sv
// Directed bench for fir_lowpass_8tap: wide-integer reference model plus hand-computed pinned values.
module tb_fir_lowpass_8tap;

    localparam longint BOUND = 64'sd1073479680;

    logic               CLK = 1'b0;
    logic               RST;
    logic signed [15:0] X;
    logic signed [31:0] Y;

    always #5 CLK = ~CLK;

    fir_lowpass_8tap dut (
        .CLK (CLK),
        .RST (RST),
        .X   (X),
        .Y   (Y)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    longint coef [8] = '{910, 2730, 5460, 7280, 7280, 5460, 2730, 910};
    longint past [7];
    logic signed [31:0] exp_y;

    logic               lit_next_en;
    logic signed [31:0] lit_next_val;
    string              lit_next_name;
    logic               lit_en;
    logic signed [31:0] lit_val;
    string              lit_name;

    // Reference: exact sum in 64 bits, then reduced modulo 2^32.
    function automatic logic signed [31:0] fir_model(input longint newest, input longint older [7]);
        longint s;
        s = coef[0] * newest;
        for (int k = 1; k < 8; k++) s += coef[k] * older[k-1];
        return 32'(s);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 7; k++) past[k] <= 0;
            exp_y  <= '0;
            lit_en <= 1'b0;
        end else begin
            past[0] <= longint'(X);
            for (int k = 1; k < 7; k++) past[k] <= past[k-1];
            exp_y    <= fir_model(longint'(X), past);
            lit_en   <= lit_next_en;
            lit_val  <= lit_next_val;
            lit_name <= lit_next_name;
        end
    end

    // Single compare point, half a cycle away from the sampling edge.
    always @(negedge CLK) begin
        if (checking) begin
            vectors++;
            if (Y !== exp_y) begin
                miscompares++;
                $display("FAIL model t=%0t: Y=%0d required %0d", $time, Y, exp_y);
            end
            if (lit_en && !RST) begin
                vectors++;
                if (Y !== lit_val) begin
                    miscompares++;
                    $display("FAIL %s t=%0t: Y=%0d required %0d", lit_name, $time, Y, lit_val);
                end
            end
            if (RST) begin
                vectors++;
                if (Y !== 32'sd0) begin
                    miscompares++;
                    $display("FAIL reset_clear t=%0t: Y=%0d required 0", $time, Y);
                end
            end
            if (longint'(Y) > BOUND || longint'(Y) < -BOUND) begin
                miscompares++;
                $display("FAIL bound t=%0t: Y=%0d exceeds magnitude %0d", $time, Y, BOUND);
            end
        end
    end

    task automatic drive(input logic [15:0] x, input bit en, input logic signed [31:0] val, input string name);
        @(posedge CLK);
        #1;
        X             = x;
        lit_next_en   = en;
        lit_next_val  = val;
        lit_next_name = name;
    endtask

    task automatic async_reset_pulse();
        @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        X           = 16'h0000;
        lit_next_en = 1'b0;
    endtask

    logic signed [31:0] imp [9] = '{32'sd29817970, 32'sd89453910, 32'sd178907820, 32'sd238543760,
                                    32'sd238543760, 32'sd178907820, 32'sd89453910, 32'sd29817970, 32'sd0};
    logic [15:0] fs4 [4] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};

    initial begin
        RST = 1'b1;
        X = '0;
        lit_next_en = 1'b0;
        lit_next_val = '0;
        lit_next_name = "none";
        repeat (2) @(posedge CLK);
        #1 checking = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Nonzero history, then asynchronous reset; zeros afterwards must give exactly 0.
        drive(16'h1234, 1'b0, 0, "");
        drive(16'h8000, 1'b0, 0, "");
        drive(16'h7FFF, 1'b0, 0, "");
        drive(16'hF00D, 1'b0, 0, "");
        async_reset_pulse();
        for (int i = 0; i < 8; i++) drive(16'h0000, 1'b1, 32'sd0, "reset_zero");

        // Impulse response on consecutive edges.
        drive(16'h7FFF, 1'b1, imp[0], "impulse");
        for (int i = 1; i < 9; i++) drive(16'h0000, 1'b1, imp[i], "impulse");

        // DC step settles to 32760*32767 on the 8th edge and holds.
        for (int i = 0; i < 12; i++) drive(16'h7FFF, (i >= 7), 32'sd1073446920, "dc_step");

        // fs/4 and fs/2 are nulled once the window is filled.
        for (int i = 0; i < 16; i++) drive(fs4[i % 4], (i >= 7), 32'sd0, "fs4_null");
        for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 16'h7FFF : 16'h8001, (i >= 7), 32'sd0, "fs2_null");

        // Square wave at full scale, reset mid-period, restart from zeroed history.
        for (int i = 0; i < 14; i++) drive((i % 9 < 5) ? 16'h7FFF : 16'h8000, 1'b0, 0, "");
        async_reset_pulse();
        drive(16'h7FFF, 1'b1, 32'sd29817970, "square_restart0");
        drive(16'h7FFF, 1'b1, 32'sd119271880, "square_restart1");
        for (int i = 2; i < 30; i++) drive((i % 9 < 5) ? 16'h7FFF : 16'h8000, 1'b0, 0, "");
        drive(16'h0000, 1'b0, 0, "");

        @(posedge CLK);
        @(negedge CLK);
        #1 checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
